// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   state_t            : controller state encoding (RUN / WAIT / FLUSH)
//   FLUSH_CYCLES_DEF   : default number of post-jump bubbles (covers sync-ROM fetch latency)
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int FLUSH_CYCLES_DEF = 1;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: turns EX jump requests, EX multi-cycle holds, data-bus wait and
// ID load-use hazards into flush (jump_en_o), freeze (hold_pc_o) and bubble (hold_flag_o)
// commands for the PC and the IF/ID, ID/EX pipeline registers.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   ex_jump_req_i/addr_i     taken branch/jump resolved in EX and its target
//   ex_hold_req_i            EX multi-cycle op busy
//   mem_wait_i               data bus not ready; whole pipeline freezes
//   ex_is_load_i, ex_rd_*    EX load and destination register (load-use detection)
//   id_rs1/rs2_addr_i, *_re_i  ID source registers and their read enables
//   jump_en_o, jump_addr_o   PC load + pipeline flush, jump target
//   hold_pc_o                PC and IF/ID keep value
//   hold_flag_o              ID/EX loads a NOP bubble
//   stall_cnt_o              saturating count of cycles with hold_pc_o=1
// Outputs are combinational from state + inputs; state and counters update on the clock.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_jump_req_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic             ex_hold_req_i,
    input  logic             mem_wait_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic             id_rs1_re_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs2_re_i,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             hold_pc_o,
    output logic             hold_flag_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
    // With no flush bubbles configured a jump returns straight to RUN.
    localparam state_t JUMP_NEXT = (FC == 3'd0) ? ST_RUN : ST_FLUSH;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic        hazard;
    logic        run_mode;

    assign hazard = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        jump_en_o   = 1'b0;
        jump_addr_o = ex_jump_addr_i;
        hold_pc_o   = 1'b0;
        hold_flag_o = 1'b0;
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        flush_cnt_d = flush_cnt_q;
        run_mode    = 1'b0;

        case (state_q)
            ST_RUN: run_mode = 1'b1;
            ST_WAIT: begin
                if (mem_wait_i) begin
                    hold_pc_o   = 1'b1;
                    hold_flag_o = 1'b1;
                    // First pending jump wins; later ones come from squashed instructions.
                    if (ex_jump_req_i && !pend_q) begin
                        pend_d      = 1'b1;
                        pend_addr_d = ex_jump_addr_i;
                    end
                end else if (pend_q) begin
                    // Replay the jump deferred by the bus wait.
                    jump_en_o   = 1'b1;
                    jump_addr_o = pend_addr_q;
                    pend_d      = 1'b0;
                    state_d     = JUMP_NEXT;
                    flush_cnt_d = FC;
                end else begin
                    run_mode = 1'b1;
                end
            end
            ST_FLUSH: begin
                // EX holds a NOP here, so jump requests and hazards are stale.
                hold_flag_o = 1'b1;
                if (mem_wait_i) begin
                    hold_pc_o = 1'b1;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (run_mode) begin
            state_d = ST_RUN;
            if (mem_wait_i) begin
                // Wait beats a simultaneous jump; the jump is deferred, not dropped.
                hold_pc_o   = 1'b1;
                hold_flag_o = 1'b1;
                state_d     = ST_WAIT;
                if (ex_jump_req_i) begin
                    pend_d      = 1'b1;
                    pend_addr_d = ex_jump_addr_i;
                end
            end else if (ex_jump_req_i) begin
                jump_en_o   = 1'b1;
                state_d     = JUMP_NEXT;
                flush_cnt_d = FC;
            end else if (ex_hold_req_i || hazard) begin
                hold_pc_o   = 1'b1;
                hold_flag_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            pend_q      <= 1'b0;
            pend_addr_q <= 32'd0;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (hold_pc_o && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_q;

endmodule
